// File: rtl/neo_coin_ctrl.sv
// Coin counter / lockout latch: synchronises nCOUNTOUT, decodes the 68k address and drives meter coils.
// Defining NEO_COIN_OVF_EN adds the sticky per-channel pending-overflow output OVF.
module neo_coin_ctrl #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MODE      = 1,
  parameter int unsigned PULSE_CYC = 24,
  parameter int unsigned GAP_CYC   = 24,
  parameter int unsigned PEND_W    = 4
) (
  input  logic                CLK_24M,
  input  logic                RESET,
  input  logic                nCOUNTOUT,
  input  logic [7:1]          M68K_ADDR,
  output logic [CHANNELS-1:0] COUNTER,
  output logic [CHANNELS-1:0] LOCKOUT,
  output logic [CHANNELS-1:0] BUSY
`ifdef NEO_COIN_OVF_EN
  ,
  output logic [CHANNELS-1:0] OVF
`endif
);

  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TMAX    = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [4:0]  CH_MASK = 5'((1 << CW) - 1);

  logic       s1, s2, s3;
  logic       wr, data, fn, valid;
  logic [4:0] ch;

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= nCOUNTOUT;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One write per falling edge of the strobe, however long it stays low.
  assign wr    = ~s2 & s3;
  assign data  = M68K_ADDR[7];
  assign fn    = M68K_ADDR[2];
  assign ch    = {M68K_ADDR[6:3], M68K_ADDR[1]} & CH_MASK;
  assign valid = wr && ({27'd0, ch} < CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic hit, lock_q;
    assign hit = valid && (ch == 5'(c));

    always_ff @(posedge CLK_24M or posedge RESET) begin
      if (RESET)            lock_q <= 1'b0;
      else if (hit && fn)   lock_q <= data;
    end
    assign LOCKOUT[c] = lock_q;

    if (MODE == 0) begin : g_level
      logic cnt_q;
      always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET)            cnt_q <= 1'b0;
        else if (hit && !fn)  cnt_q <= data;
      end
      assign COUNTER[c] = cnt_q;
      assign BUSY[c]    = 1'b0;
`ifdef NEO_COIN_OVF_EN
      assign OVF[c]     = 1'b0;
`endif
    end else begin : g_pulse
      typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
      state_t            state, state_nx;
      logic [TW-1:0]     timer, timer_nx;
      logic [PEND_W-1:0] pend, pend_nx, pend_post;
      logic              inc, sat, cnt_o, busy_o;

      assign inc = hit && !fn && data;

      always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
          state <= IDLE;
          timer <= '0;
          pend  <= '0;
        end else begin
          state <= state_nx;
          timer <= timer_nx;
          pend  <= pend_nx;
        end
      end

      // Saturation is judged after this cycle's dequeue, so a concurrent
      // increment and dequeue at max leaves pending full without overflow.
      always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        pend_post = pend;
        case (state)
          IDLE: if (pend != '0) begin
            state_nx  = ON;
            timer_nx  = TW'(PULSE_CYC - 1);
            pend_post = pend - PEND_W'(1);
          end
          ON: if (timer == '0) begin
            state_nx = GAP;
            timer_nx = TW'(GAP_CYC - 1);
          end else begin
            timer_nx = timer - TW'(1);
          end
          GAP: if (timer == '0) state_nx = IDLE;
               else             timer_nx = timer - TW'(1);
          default: state_nx = IDLE;
        endcase
        sat     = (pend_post == '1);
        pend_nx = (inc && !sat) ? pend_post + PEND_W'(1) : pend_post;
      end

      always_comb begin
        cnt_o  = (state == ON);
        busy_o = (state != IDLE) || (pend != '0);
      end
      assign COUNTER[c] = cnt_o;
      assign BUSY[c]    = busy_o;

`ifdef NEO_COIN_OVF_EN
      logic ovf_q;
      always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET)                      ovf_q <= 1'b0;
        else if (inc && sat)            ovf_q <= 1'b1;
        else if (hit && !fn && !data)   ovf_q <= 1'b0;
      end
      assign OVF[c] = ovf_q;
`endif
    end
  end

endmodule

// File: tb/tb_neo_coin_ctrl.sv
// Bench for neo_coin_ctrl: a PULSE instance (3 channels, PEND_W=2) and a LEVEL instance (2 channels)
// share one strobe/address bus and are compared every cycle against a behavioural model.
module tb_neo_coin_ctrl;
  localparam int unsigned P    = 24;
  localparam int unsigned G    = 24;
  localparam int unsigned NP   = 3;
  localparam int unsigned NL   = 2;
  localparam int          PMAX = 3;

  logic clk = 1'b0, rst = 1'b1, ncnt = 1'b1;
  logic [7:1] addr = '0;
  logic [NP-1:0] p_cnt, p_lock, p_busy;
  logic [NL-1:0] l_cnt, l_lock, l_busy;
`ifdef NEO_COIN_OVF_EN
  logic [NP-1:0] p_ovf;
  logic [NL-1:0] l_ovf;
`endif

  always #5 clk = ~clk;

  neo_coin_ctrl #(.CHANNELS(NP), .MODE(1), .PULSE_CYC(P), .GAP_CYC(G), .PEND_W(2)) u_pulse (
    .CLK_24M(clk), .RESET(rst), .nCOUNTOUT(ncnt), .M68K_ADDR(addr),
    .COUNTER(p_cnt), .LOCKOUT(p_lock), .BUSY(p_busy)
`ifdef NEO_COIN_OVF_EN
    , .OVF(p_ovf)
`endif
  );

  neo_coin_ctrl #(.CHANNELS(NL), .MODE(0), .PULSE_CYC(P), .GAP_CYC(G), .PEND_W(4)) u_level (
    .CLK_24M(clk), .RESET(rst), .nCOUNTOUT(ncnt), .M68K_ADDR(addr),
    .COUNTER(l_cnt), .LOCKOUT(l_lock), .BUSY(l_busy)
`ifdef NEO_COIN_OVF_EN
    , .OVF(l_ovf)
`endif
  );

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: per pulse channel a queue depth and the position within the
  // current pulse+gap window (-1 when no pulse is being played).
  int   m_pend[NP];
  int   m_t[NP];
  bit   m_ovf[NP];
  logic [NP-1:0] m_plock;
  logic [NL-1:0] m_lcnt, m_llock;
  int   since_fall;
  logic nc_prev;

  always @(posedge clk or posedge rst) begin
    bit wr, a7, f, dec;
    int idx, cp, cl, p;
    if (rst) begin
      for (int c = 0; c < NP; c++) begin m_pend[c] = 0; m_t[c] = -1; m_ovf[c] = 0; end
      m_plock = '0; m_lcnt = '0; m_llock = '0;
      since_fall = 0; nc_prev = 1'b1;
    end else begin
      if (!ncnt && nc_prev) since_fall = 1;
      else if (since_fall > 0) since_fall++;
      nc_prev = ncnt;
      wr  = (since_fall == 3);
      a7  = addr[7];
      f   = addr[2];
      idx = int'({addr[6:3], addr[1]});
      cp  = idx % 4;
      cl  = idx % 2;
      for (int c = 0; c < NP; c++) begin
        dec = (m_t[c] < 0) && (m_pend[c] > 0);
        if (m_t[c] >= 0) begin
          m_t[c]++;
          if (m_t[c] == int'(P + G)) m_t[c] = -1;
        end else if (dec) m_t[c] = 0;
        p = m_pend[c] - int'(dec);
        if (wr && cp == c && !f) begin
          if (a7) begin
            if (p == PMAX) m_ovf[c] = 1'b1;
            else p++;
          end else m_ovf[c] = 1'b0;
        end
        m_pend[c] = p;
      end
      if (wr && cp < int'(NP) && f) m_plock[cp] = a7;
      if (wr && f)  m_llock[cl] = a7;
      if (wr && !f) m_lcnt[cl]  = a7;
    end
  end

  always @(negedge clk) begin
    logic [NP-1:0] e_cnt, e_busy, e_ovf;
    if (!rst) begin
      for (int c = 0; c < NP; c++) begin
        e_cnt[c]  = (m_t[c] >= 0) && (m_t[c] < int'(P));
        e_busy[c] = (m_t[c] >= 0) || (m_pend[c] > 0);
        e_ovf[c]  = m_ovf[c];
      end
      check("p_counter", 32'(p_cnt), 32'(e_cnt));
      check("p_busy", 32'(p_busy), 32'(e_busy));
      check("p_lockout", 32'(p_lock), 32'(m_plock));
      check("l_counter", 32'(l_cnt), 32'(m_lcnt));
      check("l_lockout", 32'(l_lock), 32'(m_llock));
      check("l_busy", 32'(l_busy), 32'd0);
`ifdef NEO_COIN_OVF_EN
      check("p_ovf", 32'(p_ovf), 32'(e_ovf));
      check("l_ovf", 32'(l_ovf), 32'd0);
`endif
    end
  end

  // Pulse monitor on pulse channels 0 and 1.
  int rises0 = 0, rises1 = 0, hi_run0 = 0, last_hi0 = 0, lo_run0 = 0, min_lo0 = 1000;
  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (p_cnt[0]) begin
      if (!prev0) begin
        if (rises0 > 0 && lo_run0 < min_lo0) min_lo0 = lo_run0;
        rises0++;
      end
      hi_run0++;
      lo_run0 = 0;
    end else begin
      if (prev0) last_hi0 = hi_run0;
      hi_run0 = 0;
      lo_run0++;
    end
    if (p_cnt[1] && !prev1) rises1++;
    prev0 = p_cnt[0];
    prev1 = p_cnt[1];
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [7:1] mk(input logic a7, input logic f, input int idx);
    logic [4:0] i5;
    i5 = 5'(idx);
    return {a7, i5[4:1], f, i5[0]};
  endfunction

  task automatic strobe(input logic [7:1] a, input int low, input int high);
    int h;
    h = high;
    if (low + h < 3) h = 3 - low;
    if (h < 2) h = 2;
    addr = a;
    ncnt = 1'b0;
    cyc(low);
    ncnt = 1'b1;
    cyc(h);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int r0, r1;
    cyc(3);
    check("reset_outputs", {8'd0, p_cnt, p_lock, p_busy, l_cnt, l_lock, l_busy}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // LEVEL write to ch1 lands on the 3rd edge; PULSE ch1 rises on the 4th.
    addr = mk(1'b1, 1'b0, 1);
    ncnt = 1'b0;
    cyc(2);
    check("level_before_edge3", 32'(l_cnt), 32'h0);
    cyc(1);
    check("level_edge3", 32'(l_cnt), 32'h2);
    check("pulse_before_edge4", 32'(p_cnt), 32'h0);
    cyc(1);
    check("pulse_edge4", 32'(p_cnt), 32'h2);
    ncnt = 1'b1;
    cyc(2);
    strobe(mk(1'b0, 1'b0, 1), 1, 2);
    check("level_clear", 32'(l_cnt), 32'h0);
    cyc(60);

    // Single SET on ch0: exact pulse and busy timing.
    addr = mk(1'b1, 1'b0, 0);
    ncnt = 1'b0;
    cyc(1);
    ncnt = 1'b1;
    cyc(3);
    check("single_rise", 32'(p_cnt[0]), 32'h1);
    cyc(23);
    check("single_last_high", 32'(p_cnt[0]), 32'h1);
    cyc(1);
    check("single_fall", 32'(p_cnt[0]), 32'h0);
    cyc(23);
    check("single_busy_gap", 32'(p_busy[0]), 32'h1);
    cyc(1);
    check("single_busy_done", 32'(p_busy[0]), 32'h0);
    check("single_width", 32'(last_hi0), 32'd24);

    // Three SETs within 10 cycles.
    r0 = rises0; r1 = rises1;
    repeat (3) strobe(mk(1'b1, 1'b0, 0), 1, 2);
    cyc(170);
    check("three_pulses", 32'(rises0 - r0), 32'd3);
    check("three_ch1_quiet", 32'(rises1 - r1), 32'd0);
    check("three_width", 32'(last_hi0), 32'd24);

    // Five rapid SETs with a 2-bit queue: one in flight, three queued, one dropped.
    r0 = rises0;
    repeat (5) strobe(mk(1'b1, 1'b0, 0), 1, 2);
`ifdef NEO_COIN_OVF_EN
    check("ovf_set", 32'(p_ovf[0]), 32'h1);
`endif
    cyc(220);
    check("sat_pulses", 32'(rises0 - r0), 32'd4);
    strobe(mk(1'b0, 1'b0, 0), 1, 2);
`ifdef NEO_COIN_OVF_EN
    check("ovf_clear", 32'(p_ovf[0]), 32'h0);
`endif

    // Lockout during a ch0 pulse, then out-of-range writes.
    strobe(mk(1'b1, 1'b0, 0), 1, 2);
    cyc(3);
    strobe(mk(1'b1, 1'b1, 1), 1, 2);
    check("lock_pulse", 32'(p_lock), 32'h2);
    check("lock_level", 32'(l_lock), 32'h2);
    strobe(mk(1'b1, 1'b1, 3), 1, 2);
    strobe(mk(1'b1, 1'b0, 3), 1, 2);
    check("oor_lock", 32'(p_lock), 32'h2);
    check("oor_counter", 32'({p_cnt[2], p_busy[2]}), 32'h0);
    cyc(60);
    check("lock_width", 32'(last_hi0), 32'd24);

    // Randomised traffic, biased toward the populated pulse channels.
    for (int i = 0; i < 150; i++) begin
      int idx;
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 2));
      strobe(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), idx),
             int'($urandom_range(1, 4)), int'($urandom_range(2, 6)));
      if ($urandom_range(0, 9) == 0) cyc(int'($urandom_range(10, 60)));
    end
    cyc(250);
    check("min_gap", 32'(min_lo0 >= int'(G)), 32'h1);

    // Asynchronous reset in the middle of a pulse with more queued.
    repeat (3) strobe(mk(1'b1, 1'b0, 0), 1, 2);
    strobe(mk(1'b1, 1'b1, 0), 1, 2);
    cyc(2);
    #1 rst = 1'b1;
    #1;
    check("reset_async", {8'd0, p_cnt, p_lock, p_busy, l_cnt, l_lock, l_busy}, 32'd0);
    cyc(2);
    rst = 1'b0;
    r0 = rises0;
    cyc(80);
    check("reset_no_pulse", 32'(rises0 - r0), 32'd0);
    check("reset_idle_busy", 32'(p_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
